// File: rtl/sea_byte_io.sv
// Byte-serial framer for the 48-bit SEA datapath: collects key/L/R bytes, waits CORE_LAT, streams the result out.
// Optional key reuse across frames is enabled by defining SEA_KEY_KEEP_EN.
module sea_byte_io #(
   parameter int unsigned CORE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [7:0]  dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   input  logic        key_keep,
   output logic [47:0] core_ki,
   output logic [47:0] core_li,
   output logic [47:0] core_ri,
   input  logic [47:0] core_lio,
   input  logic [47:0] core_rio,
   output logic        busy
);

   typedef enum logic [2:0] {LOAD_K, LOAD_L, LOAD_R, WAIT, SEND} state_t;

   // Handshakes: a byte moves on a rising edge where valid & ready are both high;
   // dout/dout_valid are decodes of registered state only, never of dout_ready.
   state_t      state;
   logic [3:0]  bcnt;
   logic [3:0]  wcnt;
   logic [95:0] osr;
   logic        in_load;
   logic        acc;
   state_t      frame_start;

   assign in_load    = (state == LOAD_K) || (state == LOAD_L) || (state == LOAD_R);
   assign din_ready  = in_load & ~rst;
   assign acc        = din_valid & din_ready;
   assign dout_valid = (state == SEND);
   assign dout       = dout_valid ? osr[95:88] : 8'd0;
   assign busy       = (state == WAIT) || (state == SEND);

`ifdef SEA_KEY_KEEP_EN
   assign frame_start = key_keep ? LOAD_L : LOAD_K;
`else
   logic unused_key_keep;
   assign unused_key_keep = key_keep;
   assign frame_start     = LOAD_K;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= LOAD_K;
         bcnt    <= 4'd0;
         wcnt    <= 4'd0;
         osr     <= 96'd0;
         core_ki <= 48'd0;
         core_li <= 48'd0;
         core_ri <= 48'd0;
      end else begin
         case (state)
            LOAD_K: begin
               if (acc) begin
                  core_ki <= {core_ki[39:0], din};
                  if (bcnt == 4'd5) begin
                     bcnt  <= 4'd0;
                     state <= LOAD_L;
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
            end
            LOAD_L: begin
               if (acc) begin
                  core_li <= {core_li[39:0], din};
                  if (bcnt == 4'd5) begin
                     bcnt  <= 4'd0;
                     state <= LOAD_R;
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
            end
            LOAD_R: begin
               if (acc) begin
                  core_ri <= {core_ri[39:0], din};
                  if (bcnt == 4'd5) begin
                     bcnt  <= 4'd0;
                     wcnt  <= 4'(CORE_LAT - 1);
                     state <= WAIT;
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
            end
            WAIT: begin
               // The core is combinational; wcnt only gives it settling time.
               if (wcnt != 4'd0) begin
                  wcnt <= wcnt - 4'd1;
               end else begin
                  osr   <= {core_lio, core_rio};
                  state <= SEND;
               end
            end
            SEND: begin
               if (dout_ready) begin
                  osr <= {osr[87:0], 8'd0};
                  if (bcnt == 4'd11) begin
                     bcnt  <= 4'd0;
                     state <= frame_start;
                  end else begin
                     bcnt <= bcnt + 4'd1;
                  end
               end
            end
            default: state <= LOAD_K;
         endcase
      end
   end

endmodule

// File: tb/tb_sea_byte_io.sv
// Bench for sea_byte_io: two instances (CORE_LAT 1 and 4) with a loopback core, directed frames,
// expected output bytes queued at issue time and popped by an independent output monitor.
module tb_sea_byte_io;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [7:0]  din = 8'd0;
   logic        din_valid = 1'b0;
   logic        dout_ready = 1'b1;
   logic        key_keep = 1'b0;
   logic        sel = 1'b0;

   logic        din_ready_a, dout_valid_a, busy_a;
   logic [7:0]  dout_a;
   logic [47:0] ki_a, li_a, ri_a;
   logic        din_ready_b, dout_valid_b, busy_b;
   logic [7:0]  dout_b;
   logic [47:0] ki_b, li_b, ri_b;

   // Loopback core (encrypt followed by decrypt): the result equals the presented halves.
   sea_byte_io #(.CORE_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_a),
      .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready), .key_keep(key_keep),
      .core_ki(ki_a), .core_li(li_a), .core_ri(ri_a), .core_lio(li_a), .core_rio(ri_a), .busy(busy_a)
   );
   sea_byte_io #(.CORE_LAT(4)) dut_b (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_b),
      .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready), .key_keep(key_keep),
      .core_ki(ki_b), .core_li(li_b), .core_ri(ri_b), .core_lio(li_b), .core_rio(ri_b), .busy(busy_b)
   );

   logic        s_ready, s_valid, s_busy;
   logic [7:0]  s_dout;
   logic [47:0] s_ki, s_li, s_ri;
   always_comb begin
      s_ready = sel ? din_ready_b  : din_ready_a;
      s_valid = sel ? dout_valid_b : dout_valid_a;
      s_busy  = sel ? busy_b       : busy_a;
      s_dout  = sel ? dout_b       : dout_a;
      s_ki    = sel ? ki_b         : ki_a;
      s_li    = sel ? li_b         : li_a;
      s_ri    = sel ? ri_b         : ri_a;
   end

   int total = 0;
   int bad = 0;
   int out_cnt = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Sink backpressure: mode 0 always ready, mode 1 pattern 1,0,0,1,0,0,...
   int rdy_mode = 0;
   int rdy_ph = 0;
   always @(posedge clk) begin
      #2;
      if (rdy_mode == 0) dout_ready = 1'b1;
      else begin
         dout_ready = (rdy_ph % 3 == 0);
         rdy_ph++;
      end
   end

   // Output monitor: pops one expected byte per handshake, checks hold during stalls.
   logic [7:0] held = 8'd0;
   logic       stalled = 1'b0;
   always @(negedge clk) begin
      if (rst) stalled = 1'b0;
      else if (s_valid) begin
         if (stalled) check("stall_hold", {88'd0, s_dout}, {88'd0, held});
         if (dout_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_byte actual=%0h required=none", s_dout);
            end else begin
               check("dout_byte", {88'd0, s_dout}, {88'd0, exp_q.pop_front()});
            end
            out_cnt++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = s_dout;
         end
      end else stalled = 1'b0;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r;
      int n;
      n = 0;
      repeat (gap) begin
         @(negedge clk);
         din_valid = 1'b0;
      end
      @(negedge clk);
      din = b;
      din_valid = 1'b1;
      forever begin
         r = s_ready;
         @(posedge clk);
         if (r) break;
         n++;
         if (n > 50) begin
            total++;
            bad++;
            $display("FAIL din_accept_timeout actual=%0d required=<=50", n);
            break;
         end
         @(negedge clk);
      end
      #1;
   endtask

   task automatic send48(input logic [47:0] w, input int gap);
      for (int i = 5; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
   endtask

   task automatic push_exp(input logic [47:0] l, input logic [47:0] r);
      for (int i = 5; i >= 0; i--) exp_q.push_back(l[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) exp_q.push_back(r[i*8 +: 8]);
      out_cnt = 0;
   endtask

   task automatic measure_lat(input int req);
      int n;
      n = 0;
      check("busy_in_wait", {95'd0, s_busy}, 96'd1);
      while (!s_valid && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("capture_latency", n, req);
   endtask

   task automatic finish_frame(input bit hold_din, input logic [47:0] k,
                               input logic [47:0] l, input logic [47:0] r);
      int n;
      logic rdy_seen;
      n = 0;
      rdy_seen = 1'b0;
      @(negedge clk);
      while (s_busy && n < 200) begin
         if (hold_din) begin
            din_valid = 1'b1;
            din = 8'($urandom_range(0, 255));
         end else din_valid = 1'b0;
         if (s_ready !== 1'b0) rdy_seen = 1'b1;
         @(negedge clk);
         n++;
      end
      din_valid = 1'b0;
      check("frame_timeout", {95'd0, n < 200}, 96'd1);
      check("ready_low_while_busy", {95'd0, rdy_seen}, 96'd0);
      check("din_ready_after_send", {95'd0, s_ready}, 96'd1);
      check("queue_empty", exp_q.size(), 0);
      check("bytes_sent", out_cnt, 12);
      check("core_ki_hold", {48'd0, s_ki}, {48'd0, k});
      check("core_li_hold", {48'd0, s_li}, {48'd0, l});
      check("core_ri_hold", {48'd0, s_ri}, {48'd0, r});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      din_valid = 1'b0;
      #1;
      check("rst_core_ki", {48'd0, s_ki}, 96'd0);
      check("rst_core_li", {48'd0, s_li}, 96'd0);
      check("rst_core_ri", {48'd0, s_ri}, 96'd0);
      check("rst_outputs", {84'd0, s_dout, s_valid, s_busy, s_ready, 1'b0}, 96'd0);
      repeat (2) @(negedge clk);
      check("rst_din_ready", {95'd0, s_ready}, 96'd0);
      rst = 1'b0;
      exp_q.delete();
      out_cnt = 0;
   endtask

   localparam logic [47:0] K1 = 48'h0123456789AB;
   localparam logic [47:0] L1 = 48'h111122223333;
   localparam logic [47:0] R1 = 48'h444455556666;
   localparam logic [47:0] K2 = 48'hFEDCBA987654;
   localparam logic [47:0] L2 = 48'h0F1E2D3C4B5A;
   localparam logic [47:0] R2 = 48'hA5B4C3D2E1F0;
   localparam logic [47:0] LA = 48'hAAAAAAAAAAAA;
   localparam logic [47:0] R5 = 48'h555555555555;
   localparam logic [47:0] R7 = 48'h777777777777;

   initial begin
      #100000;
      total++;
      bad++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      repeat (2) @(negedge clk);

      // Round trip, CORE_LAT=1
      sel = 1'b0;
      do_reset();
      push_exp(L1, R1);
      send48(K1, 0); send48(L1, 0); send48(R1, 0);
      measure_lat(1);
      finish_frame(1'b0, K1, L1, R1);

      // Backpressure on the output
      rdy_mode = 1;
      rdy_ph = 0;
      push_exp(L1, R1);
      send48(K1, 0); send48(L1, 0); send48(R1, 0);
      measure_lat(1);
      finish_frame(1'b0, K1, L1, R1);
      rdy_mode = 0;

      // Input gaps with CORE_LAT=4
      sel = 1'b1;
      do_reset();
      push_exp(L1, R1);
      send48(K1, 1);
      check("ki_after_key", {48'd0, s_ki}, {48'd0, K1});
      send48(L1, 1); send48(R1, 1);
      measure_lat(4);
      finish_frame(1'b0, K1, L1, R1);

      // din_valid held high through WAIT/SEND
      push_exp(L2, R2);
      send48(K2, 0); send48(L2, 0); send48(R2, 0);
      measure_lat(4);
      finish_frame(1'b1, K2, L2, R2);

      // Reset in the middle of a frame, then a clean frame
      sel = 1'b0;
      do_reset();
      send48(K2, 0);
      send_byte(8'h0F, 0); send_byte(8'h1E, 0); send_byte(8'h2D, 0);
      do_reset();
      push_exp(L1, R1);
      send48(K1, 0); send48(L1, 0); send48(R1, 0);
      measure_lat(1);
      finish_frame(1'b0, K1, L1, R1);

      // Key reuse request at the end of frame 1
      do_reset();
      key_keep = 1'b1;
      push_exp(L1, R1);
      send48(K1, 0); send48(L1, 0); send48(R1, 0);
      measure_lat(1);
      finish_frame(1'b0, K1, L1, R1);
      key_keep = 1'b0;
`ifdef SEA_KEY_KEEP_EN
      push_exp(LA, R5);
      send48(LA, 0); send48(R5, 0);
      measure_lat(1);
      finish_frame(1'b0, K1, LA, R5);
`else
      push_exp(R5, R7);
      send48(LA, 0); send48(R5, 0); send48(R7, 0);
      measure_lat(1);
      finish_frame(1'b0, LA, R5, R7);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
